// File: rtl/kgp_ctrl_pkg.sv
// Shared control definitions for the KGP-RISC multi-cycle sequencer:
// state encoding, opcode/func codes, PC source selects and the legality helper.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MULW   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b11;

  localparam logic [3:0] F_ADD   = 4'd0;
  localparam logic [3:0] F_COMP  = 4'd1;
  localparam logic [3:0] F_MUL   = 4'd2;
  localparam logic [3:0] F_MULU  = 4'd3;
  localparam logic [3:0] F_AND   = 4'd4;
  localparam logic [3:0] F_XOR   = 4'd5;
  localparam logic [3:0] F_SHL   = 4'd6;
  localparam logic [3:0] F_SHR   = 4'd7;
  localparam logic [3:0] F_ADDI  = 4'd10;
  localparam logic [3:0] F_COMPI = 4'd11;
  localparam logic [3:0] F_SHLI  = 4'd12;
  localparam logic [3:0] F_SHRI  = 4'd13;
  localparam logic [3:0] F_SRAI  = 4'd14;
  localparam logic [3:0] F_SRAV  = 4'd15;

  localparam logic [3:0] F_LD = 4'd0;
  localparam logic [3:0] F_ST = 4'd1;

  localparam logic [3:0] F_BR   = 4'd0;
  localparam logic [3:0] F_CALL = 4'd1;
  localparam logic [3:0] F_RET  = 4'd2;
  localparam logic [3:0] F_JR   = 4'd3;
  localparam logic [3:0] F_BZ   = 4'd4;
  localparam logic [3:0] F_BNZ  = 4'd5;
  localparam logic [3:0] F_BS   = 4'd6;
  localparam logic [3:0] F_BNS  = 4'd7;
  localparam logic [3:0] F_BC   = 4'd9;
  localparam logic [3:0] F_BNC  = 4'd10;
  localparam logic [3:0] F_BV   = 4'd11;
  localparam logic [3:0] F_BNV  = 4'd12;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_OFF = 2'd1;
  localparam logic [1:0] PC_SRC_RS  = 2'd2;
  localparam logic [1:0] PC_SRC_R31 = 2'd3;

  // Branch legality comes from branch_cond_eval; ALU and memory rules live here.
  function automatic logic op_legal(input logic [1:0] op, input logic [3:0] func,
                                    input logic br_legal);
    logic ok;
    case (op)
      OP_ALU:  ok = (func != 4'd8) && (func != 4'd9);
      OP_MEM:  ok = (func == F_LD) || (func == F_ST);
      OP_BR:   ok = br_legal;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Resolves branch taken/legal from the branch func code and the Z/S/C/V flags.
module branch_cond_eval
  import kgp_ctrl_pkg::*;
(
  input  logic [3:0] func,
  input  logic       flag_z,
  input  logic       flag_s,
  input  logic       flag_c,
  input  logic       flag_v,
  output logic       taken,
  output logic       legal
);

  // Condition decode; func 8 and 13-15 are unassigned branch codes.
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (func)
      F_BR, F_CALL, F_RET, F_JR: taken = 1'b1;
      F_BZ:    taken = flag_z;
      F_BNZ:   taken = ~flag_z;
      F_BS:    taken = flag_s;
      F_BNS:   taken = ~flag_s;
      F_BC:    taken = flag_c;
      F_BNC:   taken = ~flag_c;
      F_BV:    taken = flag_v;
      F_BNV:   taken = ~flag_v;
      default: begin
        taken = 1'b0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the KGP-RISC core: FETCH/DECODE/EXEC/MULW/MEM/WB/TRAP,
// with bounded handshake waits and a retired-instruction counter.
module multicycle_sequencer
  import kgp_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       opcode,
  input  logic [3:0]       func,
  input  logic             flag_z,
  input  logic             flag_s,
  input  logic             flag_c,
  input  logic             flag_v,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             mul_done,
  output logic             imem_req,
  output logic             ir_load,
  output logic [3:0]       alu_control,
  output logic             alu_src,
  output logic             mul_start,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             link_write,
  output logic             flags_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam int WCW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  state_t           state_r, state_nxt_s;
  logic [1:0]       op_r;
  logic [3:0]       func_r;
  logic [WCW-1:0]   wait_cnt_r;
  logic [CNT_W-1:0] retired_r;
  logic             taken_s, br_legal_s, retire_s, wait_state_s;
  logic             imem_req_s, ir_load_s, alu_src_s, mul_start_s, dmem_req_s, dmem_we_s;
  logic             mem_to_reg_s, reg_write_s, link_write_s, flags_write_s, pc_write_s, trap_s;
  logic [3:0]       alu_control_s;
  logic [1:0]       pc_src_s;

  branch_cond_eval u_cond (
    .func   (func_r),
    .flag_z (flag_z),
    .flag_s (flag_s),
    .flag_c (flag_c),
    .flag_v (flag_v),
    .taken  (taken_s),
    .legal  (br_legal_s)
  );

  assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MULW) || (state_r == S_MEM);

  // State, instruction latch, wait and retire counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_FETCH;
      op_r       <= 2'b00;
      func_r     <= 4'd0;
      wait_cnt_r <= {WCW{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (ir_load_s) begin
        op_r   <= opcode;
        func_r <= func;
      end
      if (state_nxt_s != state_r) begin
        wait_cnt_r <= {WCW{1'b0}};
      end else if (wait_state_s) begin
        wait_cnt_r <= wait_cnt_r + WCW'(1);
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode; only the handshake that completes a wait is looked at.
  always_comb begin
    state_nxt_s   = state_r;
    retire_s      = 1'b0;
    imem_req_s    = 1'b0;
    ir_load_s     = 1'b0;
    alu_control_s = 4'd0;
    alu_src_s     = 1'b0;
    mul_start_s   = 1'b0;
    dmem_req_s    = 1'b0;
    dmem_we_s     = 1'b0;
    mem_to_reg_s  = 1'b0;
    reg_write_s   = 1'b0;
    link_write_s  = 1'b0;
    flags_write_s = 1'b0;
    pc_write_s    = 1'b0;
    pc_src_s      = PC_SRC_INC;
    trap_s        = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_load_s   = 1'b1;
          state_nxt_s = S_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_legal(op_r, func_r, br_legal_s)) begin
          state_nxt_s = S_EXEC;
        end else begin
          state_nxt_s = S_TRAP;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_ALU: begin
            alu_control_s = func_r;
            alu_src_s     = (func_r >= F_ADDI);
            if ((func_r == F_MUL) || (func_r == F_MULU)) begin
              mul_start_s = 1'b1;
              state_nxt_s = S_MULW;
            end else begin
              state_nxt_s = S_WB;
            end
          end
          OP_MEM: begin
            alu_src_s   = 1'b1;
            state_nxt_s = S_MEM;
          end
          OP_BR: begin
            pc_write_s  = 1'b1;
            retire_s    = 1'b1;
            state_nxt_s = S_FETCH;
            case (func_r)
              F_CALL: begin
                pc_src_s     = PC_SRC_OFF;
                link_write_s = 1'b1;
              end
              F_RET:   pc_src_s = PC_SRC_R31;
              F_JR:    pc_src_s = PC_SRC_RS;
              default: pc_src_s = taken_s ? PC_SRC_OFF : PC_SRC_INC;
            endcase
          end
          default: state_nxt_s = S_TRAP;
        endcase
      end
      S_MULW: begin
        alu_control_s = func_r;
        if (mul_done) begin
          state_nxt_s = S_WB;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_MULW;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (func_r == F_ST);
        if (dmem_ready) begin
          if (func_r == F_ST) begin
            pc_write_s  = 1'b1;
            retire_s    = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_WB;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s   = 1'b1;
        mem_to_reg_s  = (op_r == OP_MEM);
        flags_write_s = (op_r == OP_ALU);
        pc_write_s    = 1'b1;
        retire_s      = 1'b1;
        state_nxt_s   = S_FETCH;
      end
      S_TRAP: begin
        trap_s      = 1'b1;
        state_nxt_s = S_TRAP;
      end
      default: state_nxt_s = S_TRAP;
    endcase
  end

  assign imem_req    = imem_req_s    & ~rst;
  assign ir_load     = ir_load_s     & ~rst;
  assign alu_control = rst ? 4'd0 : alu_control_s;
  assign alu_src     = alu_src_s     & ~rst;
  assign mul_start   = mul_start_s   & ~rst;
  assign dmem_req    = dmem_req_s    & ~rst;
  assign dmem_we     = dmem_we_s     & ~rst;
  assign mem_to_reg  = mem_to_reg_s  & ~rst;
  assign reg_write   = reg_write_s   & ~rst;
  assign link_write  = link_write_s  & ~rst;
  assign flags_write = flags_write_s & ~rst;
  assign pc_write    = pc_write_s    & ~rst;
  assign pc_src      = rst ? 2'd0 : pc_src_s;
  assign trap        = trap_s        & ~rst;
  assign retired     = rst ? {CNT_W{1'b0}} : retired_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-cycle {inputs, expected outputs} records, built from a literal
// table plus an instruction-level schedule model, applied and compared one cycle at a time.
module tb_multicycle_sequencer;
  import kgp_ctrl_pkg::*;

  localparam int WL = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic          imem_req;
    logic          ir_load;
    logic [3:0]    alu_control;
    logic          alu_src;
    logic          mul_start;
    logic          dmem_req;
    logic          dmem_we;
    logic          mem_to_reg;
    logic          reg_write;
    logic          link_write;
    logic          flags_write;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          trap;
    logic [CW-1:0] retired;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [1:0] opcode;
    logic [3:0] func;
    logic [3:0] flags;
    logic       imem_ready;
    logic       dmem_ready;
    logic       mul_done;
    byte        tag;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, imem_ready, dmem_ready, mul_done, flag_z, flag_s, flag_c, flag_v;
  logic [1:0] opcode;
  logic [3:0] func;
  logic imem_req, ir_load, alu_src, mul_start, dmem_req, dmem_we, mem_to_reg;
  logic reg_write, link_write, flags_write, pc_write, trap;
  logic [3:0] alu_control;
  logic [1:0] pc_src;
  logic [CW-1:0] retired;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ret_m = 0;
  vec_t q[$];
  vec_t tbl[6];

  always #5 clk = ~clk;

  multicycle_sequencer #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c), .flag_v(flag_v),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .mul_done(mul_done),
    .imem_req(imem_req), .ir_load(ir_load), .alu_control(alu_control), .alu_src(alu_src),
    .mul_start(mul_start), .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .link_write(link_write), .flags_write(flags_write),
    .pc_write(pc_write), .pc_src(pc_src), .trap(trap), .retired(retired)
  );

  function automatic logic legal_m(input logic [1:0] op, input logic [3:0] fn);
    logic [15:0] m;
    case (op)
      2'b00:   m = 16'hFCFF;
      2'b01:   m = 16'h0003;
      2'b11:   m = 16'h1EFF;
      default: m = 16'h0000;
    endcase
    return m[fn];
  endfunction

  // flags packed as {v,c,s,z}; conditions come in (true, negated) pairs
  function automatic logic taken_m(input logic [3:0] fn, input logic [3:0] flg);
    int k;
    if (fn < 4) return 1'b1;
    k = (fn < 8) ? (int'(fn) - 4) : (int'(fn) - 5);
    return flg[k / 2] ^ ((k % 2) == 1);
  endfunction

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.retired = CW'(ret_m);
    return o;
  endfunction

  function automatic vec_t noise();
    vec_t v;
    v.rst        = 1'b0;
    v.opcode     = 2'($urandom);
    v.func       = 4'($urandom);
    v.flags      = 4'($urandom);
    v.imem_ready = 1'($urandom);
    v.dmem_ready = 1'($urandom);
    v.mul_done   = 1'($urandom);
    v.tag        = "x";
    v.exp        = '0;
    return v;
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] op, input logic [3:0] fn,
                              input logic ir, input byte t, input outs_t e);
    vec_t v;
    v = noise();
    v.rst = r; v.opcode = op; v.func = fn; v.imem_ready = ir; v.tag = t; v.exp = e;
    return v;
  endfunction

  task automatic push(input vec_t v, input byte t, input outs_t e);
    v.tag = t;
    v.exp = e;
    q.push_back(v);
  endtask

  task automatic push_rst();
    vec_t v;
    v = noise();
    v.rst = 1'b1;
    push(v, "R", '0);
    ret_m = 0;
  endtask

  task automatic trap_out();
    outs_t w;
    w = base();
    w.trap = 1'b1;
    push(noise(), "T", w);
    push(noise(), "T", w);
    push_rst();
  endtask

  // One instruction: d_imem / d_wait idle cycles before the handshake (>=WL means timeout);
  // rst_at >= 0 asserts reset on that wait cycle instead.
  task automatic plan_instr(input logic [1:0] op, input logic [3:0] fn, input logic [3:0] flg,
                            input int d_imem, input int d_wait, input int rst_at);
    vec_t v;
    outs_t w;
    logic is_mem;
    w = base();
    w.imem_req = 1'b1;
    for (int i = 0; i < d_imem && i < WL; i++) begin
      v = noise(); v.imem_ready = 1'b0; push(v, "F", w);
    end
    if (d_imem >= WL) begin trap_out(); return; end
    v = noise(); v.imem_ready = 1'b1; v.opcode = op; v.func = fn;
    w.ir_load = 1'b1;
    push(v, "F", w);
    push(noise(), "D", base());
    if (!legal_m(op, fn)) begin trap_out(); return; end
    v = noise(); v.flags = flg;
    w = base();
    if (op == 2'b11) begin
      w.pc_write = 1'b1;
      if (fn == 4'd1) begin w.pc_src = 2'd1; w.link_write = 1'b1; end
      else if (fn == 4'd2) w.pc_src = 2'd3;
      else if (fn == 4'd3) w.pc_src = 2'd2;
      else w.pc_src = taken_m(fn, flg) ? 2'd1 : 2'd0;
      push(v, "E", w);
      ret_m = (ret_m + 1) % (1 << CW);
      return;
    end
    is_mem = (op == 2'b01);
    if (is_mem) begin
      w.alu_src = 1'b1;
      push(v, "E", w);
      w = base(); w.dmem_req = 1'b1; w.dmem_we = (fn == 4'd1);
    end else begin
      w.alu_control = fn;
      w.alu_src = (fn >= 4'd10);
      w.mul_start = (fn == 4'd2) || (fn == 4'd3);
      push(v, "E", w);
      w = base(); w.alu_control = fn;
    end
    if (is_mem || fn == 4'd2 || fn == 4'd3) begin
      for (int i = 0; i < d_wait && i < WL; i++) begin
        if (i == rst_at) begin push_rst(); return; end
        v = noise();
        if (is_mem) v.dmem_ready = 1'b0; else v.mul_done = 1'b0;
        push(v, is_mem ? "M" : "U", w);
      end
      if (d_wait >= WL) begin trap_out(); return; end
      v = noise();
      if (is_mem) v.dmem_ready = 1'b1; else v.mul_done = 1'b1;
      if (is_mem && fn == 4'd1) begin
        w.pc_write = 1'b1;
        push(v, "M", w);
        ret_m = (ret_m + 1) % (1 << CW);
        return;
      end
      push(v, is_mem ? "M" : "U", w);
    end
    w = base();
    w.reg_write = 1'b1; w.pc_write = 1'b1;
    w.mem_to_reg = is_mem; w.flags_write = !is_mem;
    push(noise(), "W", w);
    ret_m = (ret_m + 1) % (1 << CW);
  endtask

  task automatic apply(input vec_t v);
    outs_t got;
    @(negedge clk);
    rst = v.rst; opcode = v.opcode; func = v.func;
    flag_z = v.flags[0]; flag_s = v.flags[1]; flag_c = v.flags[2]; flag_v = v.flags[3];
    imem_ready = v.imem_ready; dmem_ready = v.dmem_ready; mul_done = v.mul_done;
    #2;
    got.imem_req = imem_req; got.ir_load = ir_load; got.alu_control = alu_control;
    got.alu_src = alu_src; got.mul_start = mul_start; got.dmem_req = dmem_req;
    got.dmem_we = dmem_we; got.mem_to_reg = mem_to_reg; got.reg_write = reg_write;
    got.link_write = link_write; got.flags_write = flags_write; got.pc_write = pc_write;
    got.pc_src = pc_src; got.trap = trap; got.retired = retired;
    total++;
    if (got !== v.exp) begin
      bad++;
      $display("FAIL outputs[%c] cycle %0d: got=%h expected=%h", v.tag, cyc, got, v.exp);
    end
    cyc++;
  endtask

  initial begin
    outs_t e;
    rst = 1'b1; opcode = 2'b00; func = 4'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
    mul_done = 1'b0; flag_z = 1'b0; flag_s = 1'b0; flag_c = 1'b0; flag_v = 1'b0;

    // add with zero-wait fetch: reset, FETCH, DECODE, EXEC, WB, then retired=1
    e = '0;                                        tbl[0] = mk(1'b1, 2'b00, 4'd0, 1'b1, "R", e);
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;   tbl[1] = mk(1'b0, 2'b00, 4'd0, 1'b1, "F", e);
    e = '0;                                        tbl[2] = mk(1'b0, 2'b10, 4'd8, 1'b1, "D", e);
    e = '0;                                        tbl[3] = mk(1'b0, 2'b10, 4'd9, 1'b1, "E", e);
    e = '0; e.reg_write = 1'b1; e.flags_write = 1'b1; e.pc_write = 1'b1;
                                                   tbl[4] = mk(1'b0, 2'b01, 4'd3, 1'b1, "W", e);
    e = '0; e.imem_req = 1'b1; e.retired = 4'd1;   tbl[5] = mk(1'b0, 2'b11, 4'd4, 1'b0, "F", e);
    for (int i = 0; i < 6; i++) apply(tbl[i]);

    push_rst();
    plan_instr(2'b00, 4'd0,  4'h0, 2, 0, -1);
    plan_instr(2'b00, 4'd2,  4'h0, 0, 2, -1);
    plan_instr(2'b00, 4'd3,  4'h0, 1, 0, -1);
    plan_instr(2'b00, 4'd10, 4'h0, 0, 0, -1);
    plan_instr(2'b00, 4'd15, 4'h0, 0, 0, -1);
    plan_instr(2'b01, 4'd0,  4'h0, 0, 3, -1);
    plan_instr(2'b01, 4'd1,  4'h0, 1, 0, -1);
    plan_instr(2'b11, 4'd1,  4'h0, 0, 0, -1);
    plan_instr(2'b11, 4'd2,  4'h0, 0, 0, -1);
    plan_instr(2'b11, 4'd3,  4'h0, 0, 0, -1);
    plan_instr(2'b11, 4'd0,  4'h0, 0, 0, -1);
    for (int fn = 4; fn <= 12; fn++) begin
      if (fn == 8) continue;
      for (int f = 0; f < 16; f++) plan_instr(2'b11, 4'(fn), 4'(f), 0, 0, -1);
    end
    plan_instr(2'b01, 4'd0, 4'h0, 0, 3, 2);
    plan_instr(2'b00, 4'd1, 4'h0, 0, 0, -1);
    plan_instr(2'b10, 4'd0, 4'h0, 0, 0, -1);
    plan_instr(2'b11, 4'd8, 4'h0, 0, 0, -1);
    plan_instr(2'b00, 4'd9, 4'h0, 0, 0, -1);
    plan_instr(2'b01, 4'd2, 4'h0, 0, 0, -1);
    plan_instr(2'b01, 4'd0, 4'h0, 0, 4, -1);
    plan_instr(2'b00, 4'd2, 4'h0, 0, 4, -1);
    plan_instr(2'b00, 4'd0, 4'h0, 4, 0, -1);

    for (int n = 0; n < 250; n++) begin
      int sel, di, dw;
      logic [1:0] op;
      logic [3:0] fn;
      sel = $urandom_range(0, 19);
      if (sel == 0) op = 2'b10;
      else if (sel < 8) op = 2'b00;
      else if (sel < 13) op = 2'b01;
      else op = 2'b11;
      fn = (op == 2'b01) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      di = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 2) : 4;
      dw = ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : 4;
      plan_instr(op, fn, 4'($urandom), di, dw, -1);
    end

    foreach (q[i]) apply(q[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
